// File: rtl/chop_pkg.sv
// chop shared helpers.
// Width-independent utilities only.
package chop_pkg;

  function automatic logic [31:0] effective_size(
    input logic [31:0] size
  );
    return (size == 32'd0) ? 32'd1 : size;
  endfunction

endpackage

// File: rtl/dti.sv
// dti valid/ready stream interface.
// Producer drives data/valid, consumer drives ready.
interface dti #(
  parameter int W = 1
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport producer (
    output data,
    output valid,
    input  ready
  );

  modport consumer (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/chop.sv
// chop: splits innermost sub-queues into size-element
// chunks and adds a new innermost eot level.
module chop
  import chop_pkg::*;
#(
  parameter int TDIN    = 16,
  parameter int DIN_LVL = 1,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic rst,
  dti.consumer din,
  dti.consumer cfg,
  dti.producer dout
);

  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   last_idx;
  logic [DIN_LVL-1:0] eot_in;
  logic               chunk_end;
  logic               xfer;

  assign last_idx = CNT_W'(
    effective_size(32'(cfg.data)) - 32'd1);
  assign chunk_end = (cnt == last_idx);

  assign dout.valid = din.valid & cfg.valid;
  assign din.ready  = dout.ready & cfg.valid;
  assign xfer       = dout.valid & dout.ready;
  assign cfg.ready  = xfer & eot_in[0];

  if (TDIN > 0) begin : g_data
    typedef struct packed {
      logic [DIN_LVL-1:0] eot;
      logic [TDIN-1:0]    data;
    } din_t;
    typedef struct packed {
      logic [DIN_LVL:0] eot;
      logic [TDIN-1:0]  data;
    } dout_t;

    din_t  di;
    dout_t dq;

    assign di        = din.data;
    assign eot_in    = di.eot;
    assign dq.eot    = {di.eot, chunk_end | di.eot[0]};
    assign dq.data   = di.data;
    assign dout.data = dq;
  end else begin : g_eot
    assign eot_in    = din.data;
    assign dout.data = {eot_in, chunk_end | eot_in[0]};
  end

  // A sub-queue end always closes the chunk, so a short
  // tail chunk never carries its count into the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (xfer) begin
      if (eot_in[0] | chunk_end) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_chop.sv
// Randomized bench for chop against a positional
// chunk model, plus literal eot[0] patterns.
module tb_chop;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dti #(.W(9))  d0_in  ();
  dti #(.W(16)) c0     ();
  dti #(.W(10)) d0_out ();
  dti #(.W(2))  d1_in  ();
  dti #(.W(16)) c1     ();
  dti #(.W(3))  d1_out ();

  chop #(.TDIN(8), .DIN_LVL(1), .CNT_W(16)) u0 (
    .clk  (clk),
    .rst  (rst),
    .din  (d0_in),
    .cfg  (c0),
    .dout (d0_out)
  );

  chop #(.TDIN(0), .DIN_LVL(2), .CNT_W(16)) u1 (
    .clk  (clk),
    .rst  (rst),
    .din  (d1_in),
    .cfg  (c1),
    .dout (d1_out)
  );

  int errs = 0;
  int checks = 0;
  int cfg_pulses = 0;
  int k;
  logic [9:0] expq[$];
  bit seen[$];
  logic [9:0] e;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [31:0] packed_seen();
    logic [31:0] v;
    v = '0;
    foreach (seen[i]) v[i] = seen[i];
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("dout_valid", d0_out.valid,
          d0_in.valid & c0.valid);
      chk("din_ready", d0_in.ready,
          d0_out.ready & c0.valid);
      chk("cfg_ready", c0.ready,
          d0_out.valid & d0_out.ready & d0_in.data[8]);
      if (d0_out.valid && d0_out.ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_xfer", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("dout", d0_out.data, e);
          seen.push_back(d0_out.data[8]);
        end
        if (c0.ready) cfg_pulses++;
      end
    end
  end

  task automatic pulse_rst();
    d0_in.valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Expected eot[0] from position within the chunk segment.
  task automatic send_sq(input int len, input int size,
                         input bit stall,
                         input int rst_at = -1);
    bit cfg_on;
    bit hs;
    bit last;
    int g;
    int s;
    logic [7:0] d;
    cfg_on = 1'b0;
    k = 0;
    s = (size == 0) ? 1 : size;
    for (int i = 0; i < len; i++) begin
      if (i == rst_at) begin
        pulse_rst();
        k = 0;
      end
      last = (i == len - 1);
      d = 8'($urandom);
      expq.push_back({last,
                      last || ((k + 1) % s == 0), d});
      d0_in.valid = 1'b1;
      d0_in.data = {last, d};
      c0.data = 16'(size);
      g = 0;
      do begin
        if (!cfg_on)
          cfg_on = !stall || ($urandom_range(0, 2) == 0);
        c0.valid = cfg_on;
        d0_out.ready = !stall ||
                       1'($urandom_range(0, 1));
        @(negedge clk);
        hs = d0_out.valid && d0_out.ready;
        @(posedge clk);
        #1;
        g++;
      end while (!hs && g < 100);
      if (!hs) chk("timeout", 0, 1);
      k++;
    end
    d0_in.valid = 1'b0;
    c0.valid = 1'b0;
  endtask

  logic l0, l1, e0;
  int sz1, s1;

  initial begin
    rst = 1'b1;
    d0_in.valid = 1'b0; d0_in.data = '0;
    c0.valid = 1'b0; c0.data = '0;
    d0_out.ready = 1'b0;
    d1_in.valid = 1'b0; d1_in.data = '0;
    c1.valid = 1'b0; c1.data = '0;
    d1_out.ready = 1'b0;
    #12;
    chk("rst_dout_valid", d0_out.valid, 0);
    chk("rst_cfg_ready", c0.ready, 0);
    chk("rst_din_ready", d0_in.ready, 0);
    c0.valid = 1'b1;
    d0_out.ready = 1'b1;
    #1;
    chk("rst_din_ready_follow", d0_in.ready, 1);
    c0.valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    seen.delete(); cfg_pulses = 0;
    send_sq(7, 3, 0);
    chk("t1_eot0", packed_seen(), 32'h64);
    chk("t1_cfg_pulses", cfg_pulses, 1);

    seen.delete();
    send_sq(8, 4, 0);
    send_sq(3, 4, 0);
    chk("t2_eot0", packed_seen(), 32'h488);

    seen.delete();
    send_sq(4, 0, 0);
    send_sq(5, 2, 0);
    chk("t3_eot0", packed_seen(), 32'h1af);

    seen.delete();
    send_sq(13, 5, 0);
    chk("t4_nostall", packed_seen(), 32'h1210);
    seen.delete();
    send_sq(13, 5, 1);
    chk("t4_stall", packed_seen(), 32'h1210);

    seen.delete();
    send_sq(9, 5, 0, 2);
    chk("t5_reset", packed_seen(), 32'h140);

    seen.delete();
    send_sq(5, 65535, 0);
    chk("t6_maxsize", packed_seen(), 32'h10);

    for (int n = 0; n < 25; n++)
      send_sq($urandom_range(1, 16),
              $urandom_range(0, 7),
              1'($urandom_range(0, 1)));
    @(negedge clk);
    chk("queue_drained", expq.size(), 0);

    k = 0;
    sz1 = $urandom_range(0, 4);
    c1.data = 16'(sz1);
    c1.valid = 1'b1;
    d1_in.valid = 1'b1;
    d1_out.ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      l0 = (i == 39) || ($urandom_range(0, 3) == 0);
      l1 = l0 && ((i == 39) ||
                  ($urandom_range(0, 1) == 1));
      s1 = (sz1 == 0) ? 1 : sz1;
      e0 = l0 || ((k + 1) % s1 == 0);
      d1_in.data = {l1, l0};
      @(negedge clk);
      chk("lvl2_dout", d1_out.data, {l1, l0, e0});
      chk("lvl2_flatten", d1_out.data[2:1], {l1, l0});
      chk("lvl2_cfg_ready", c1.ready, l0);
      @(posedge clk);
      #1;
      if (l0) begin
        k = 0;
        sz1 = $urandom_range(0, 4);
        c1.data = 16'(sz1);
      end else begin
        k++;
      end
    end
    d1_in.valid = 1'b0;
    c1.valid = 1'b0;

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule

// File: doc/chop.md
Name: chop

Overview:
- Increases a queue's level by one: splits each innermost sub-queue of din into chunks of `size` elements and marks each chunk end with a new innermost eot bit.
- Dual of level-merging flatten; feeding chop's dout into a one-level flatten returns the original din stream.
- Sits on dti streams between a data producer and consumers that process fixed-size chunks (e.g. burst writers, row splitters).

Parameters:
- TDIN, 16, data field width in bits; 0 means eot-only queue with no data field.
- DIN_LVL, 1, eot level of din; must be >= 1.
- CNT_W, 16, width of the size config and of the internal element counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- din  dti.consumer  TDIN+DIN_LVL  input queue, packed {eot[DIN_LVL-1:0], data[TDIN-1:0]}.
- cfg  dti.consumer  CNT_W  chunk size, held for one full innermost din sub-queue.
- dout  dti.producer  TDIN+DIN_LVL+1  output queue, packed {eot[DIN_LVL:0], data[TDIN-1:0]}.

Behaviour:
- State: cnt[CNT_W-1:0], count of elements already emitted in the current chunk. Reset value 0 (async on rst high).
- Effective size: sz = (cfg.data == 0) ? 1 : cfg.data. Size 0 is treated as 1.
- Combinational forward path, zero latency:
  - dout.valid = din.valid & cfg.valid
  - din.ready = dout.ready & cfg.valid
  - cfg.ready = dout.valid & dout.ready & din.eot[0]
- Handshake: xfer = dout.valid & dout.ready.
  - cfg is consumed only on the last element of an innermost din sub-queue.
  - dti rules apply: din and cfg data stable while valid until handshake; no valid deassertion before handshake.
- Output data:
  - dout.data = din.data
  - dout.eot[DIN_LVL:1] = din.eot[DIN_LVL-1:0]
  - dout.eot[0] = chunk_end | din.eot[0], where chunk_end = (cnt == sz-1)
- Counter update on xfer:
  - If din.eot[0] or chunk_end, cnt <= 0.
  - Else cnt <= cnt + 1.
  - No update without xfer.
- Boundaries:
  - Sub-queue length not a multiple of sz: last chunk is short and closed by din.eot[0]; cnt restarts at 0 for the next sub-queue.
  - chunk_end and din.eot[0] on the same element: a single eot[0] pulse, no empty chunk is emitted.
  - cnt never exceeds sz-1, so there is no wrap-around. sz = 2^CNT_W-1 is the maximum.
  - cfg.valid low: both din.ready and dout.valid are held low, and cnt holds.
  - cfg changing between sub-queues: the new sz takes effect from the first element of the next sub-queue.
  - Reset mid-sub-queue: cnt returns to 0; the next element starts a fresh chunk.
  - Outputs have no registered state, so dout/din.ready/cfg.ready follow inputs immediately after reset.
- TDIN == 0: the data field is omitted and dout carries eot only (width DIN_LVL+1).

Decomposition:
- Package chop_pkg holds only CNT_W-independent helpers (function effective_size).
- The din/dout packed struct typedefs depend on module parameters and are declared locally in generate branches for the TDIN>0 and TDIN==0 cases.
- No sub-module: a single counter plus combinational logic.

Test Plan:
- DIN_LVL=1, TDIN=8, cfg=3, din 0..6 with eot on element 6 -> dout eot[0] on elements 2, 5, 6; eot[1] on element 6 only; cfg.ready pulses once, on element 6.
- cfg=4, sub-queue of exactly 8 elements -> eot[0] on elements 3 and 7 only; the next sub-queue's first element has cnt=0.
- cfg=0 -> treated as 1, eot[0] set on every element. Then cfg=2 on the next sub-queue -> eot[0] on every 2nd element.
- Random dout.ready backpressure and cfg.valid gaps, cfg=5, 13-element sub-queue -> identical output sequence to the no-stall run; din.ready low whenever cfg.valid is low.
- rst asserted after 2 of 5 elements (cfg=5) -> next element has cnt=0; eot[0] lands 5 elements after reset or at din eot.
- DIN_LVL=2, TDIN=0 -> dout eot[2:1] equals din eot[1:0]; chaining with a one-level flatten reproduces din exactly.
